// File: rtl/abs_diff_sweep_pkg.sv
// Package for the abs_diff error-sweep harness.
// Holds the harness geometry (input/output widths, error threshold), the FSM
// state type and the two arithmetic helpers shared by the top and the
// accumulator:
//   abs_diff_exact(a, b) : exact |a-b| of the two operand halves, zero-extended
//                          to OUT_W bits
//   abs_err(x, y)        : |x-y| of two OUT_W-bit values, saturated to OUT_W bits
package abs_diff_sweep_pkg;

  localparam int IN_W   = 4;          // approximate-circuit input count
  localparam int OUT_W  = 3;          // approximate-circuit output width
  localparam int ET     = 2;          // pass iff worst-case error <= ET
  localparam int HALF_W = IN_W / 2;   // operand width (a and b)
  localparam int CNT_W  = IN_W + 1;   // error counter width, holds 2^IN_W

  localparam logic [IN_W-1:0]  STIM_LAST = '1;
  localparam logic [OUT_W-1:0] ET_V      = OUT_W'(ET);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    DONE
  } state_t;

  // One extra bit of signed headroom makes the operand difference exact.
  function automatic logic [OUT_W-1:0] abs_diff_exact(input logic [HALF_W-1:0] a,
                                                      input logic [HALF_W-1:0] b);
    logic signed [HALF_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d < 0) d = -d;
    return OUT_W'($unsigned(d));
  endfunction

  function automatic logic [OUT_W-1:0] abs_err(input logic [OUT_W-1:0] x,
                                               input logic [OUT_W-1:0] y);
    logic signed [OUT_W:0] d;
    d = $signed({1'b0, x}) - $signed({1'b0, y});
    if (d < 0) d = -d;
    // Saturate rather than wrap if the magnitude ever needs the extra bit.
    return d[OUT_W] ? '1 : d[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/abs_diff_err_acc.sv
// Stage-2 error accumulator for the abs_diff error sweep.
// Tracks the worst-case error and the number of vectors with nonzero error,
// and registers the pass verdict when the sweep finishes.
// Configuration macro: ABS_DIFF_FIRST_FAIL_EN adds capture of the first vector
// (in sweep order) whose error exceeds ET.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        start of a new sweep: zero all results
//   valid        err (and stim) belong to a swept vector this cycle
//   err          saturated |exact - approx| for that vector
//   stim         the vector itself (first-fail build only)
//   finish       last accumulation cycle: register the pass verdict
//   max_err      worst-case error so far
//   err_cnt      vectors with nonzero error so far
//   pass         max_err <= ET, valid once finish has been seen
//   fail_vec     first vector with err > ET (first-fail build only)
//   fail_seen    fail_vec holds a captured vector (first-fail build only)
module abs_diff_err_acc
  import abs_diff_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             valid,
  input  logic [OUT_W-1:0] err,
`ifdef ABS_DIFF_FIRST_FAIL_EN
  input  logic [IN_W-1:0]  stim,
  output logic [IN_W-1:0]  fail_vec,
  output logic             fail_seen,
`endif
  input  logic             finish,
  output logic [OUT_W-1:0] max_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             pass
);

  // The verdict is taken in the same edge as the last accumulation, so it has
  // to see the maximum including the vector being folded in right now.
  logic [OUT_W-1:0] max_next;
  assign max_next = (valid && (err > max_err)) ? err : max_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_err <= '0;
      err_cnt <= '0;
      pass    <= 1'b0;
    end else if (clear) begin
      max_err <= '0;
      err_cnt <= '0;
      pass    <= 1'b0;
    end else begin
      max_err <= max_next;
      if (valid && (err != '0)) err_cnt <= err_cnt + 1'b1;
      if (finish) pass <= (max_next <= ET_V);
    end
  end

`ifdef ABS_DIFF_FIRST_FAIL_EN
  // Only the first violation in sweep order is kept; later ones are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_vec  <= '0;
      fail_seen <= 1'b0;
    end else if (clear) begin
      fail_vec  <= '0;
      fail_seen <= 1'b0;
    end else if (valid && !fail_seen && (err > ET_V)) begin
      fail_vec  <= stim;
      fail_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/abs_diff_err_sweep.sv
// Exhaustive error-checking harness around one combinational approximate
// abs_diff circuit. Drives every input vector in order, registers the vector
// together with the circuit's answer, then compares against exact |a-b| and
// accumulates worst-case error, error count and a pass verdict.
// Configuration macro: ABS_DIFF_FIRST_FAIL_EN adds fail_vec_o / fail_seen_o.
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   start_i       one-cycle pulse; launches a sweep from IDLE or DONE
//   stim_o        vector to the approximate circuit; a = low half, b = high half
//   approx_i      approximate circuit output, combinational from stim_o
//   busy_o        sweep or pipeline drain in progress
//   done_o        results complete and stable
//   pass_o        max_err_o <= ET (valid while done_o)
//   max_err_o     worst-case |exact - approx|
//   err_cnt_o     number of vectors with nonzero error
//   fail_vec_o    first vector with error above ET (first-fail build only)
//   fail_seen_o   a violating vector was captured (first-fail build only)
module abs_diff_err_sweep
  import abs_diff_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  output logic [IN_W-1:0]  stim_o,
  input  logic [OUT_W-1:0] approx_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [OUT_W-1:0] max_err_o,
`ifdef ABS_DIFF_FIRST_FAIL_EN
  output logic [IN_W-1:0]  fail_vec_o,
  output logic             fail_seen_o,
`endif
  output logic [CNT_W-1:0] err_cnt_o
);

  state_t state, state_nxt;
  logic   launch;

  // NOTE: every signal assigned in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    unique case (state)
      IDLE, DONE: if (start_i) begin
        state_nxt = SWEEP;
        launch    = 1'b1;
      end
      SWEEP:   if (stim_o == STIM_LAST) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Stimulus counter: restarts at 0 on launch, steps once per SWEEP cycle and
  // parks on the last vector so it never wraps inside a sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim_o <= '0;
    end else if (launch) begin
      stim_o <= '0;
    end else if ((state == SWEEP) && (stim_o != STIM_LAST)) begin
      stim_o <= stim_o + 1'b1;
    end
  end

  // Stage 1: the vector and the circuit's answer to it travel together.
  logic             pipe_valid;
  logic [IN_W-1:0]  pipe_stim;
  logic [OUT_W-1:0] pipe_approx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid  <= 1'b0;
      pipe_stim   <= '0;
      pipe_approx <= '0;
    end else begin
      pipe_valid  <= (state == SWEEP);
      pipe_stim   <= stim_o;
      pipe_approx <= approx_i;
    end
  end

  // Stage 2 arithmetic: exact reference, then distance to the approximation.
  logic [OUT_W-1:0] err;
  assign err = abs_err(abs_diff_exact(pipe_stim[HALF_W-1:0], pipe_stim[IN_W-1:HALF_W]),
                       pipe_approx);

  abs_diff_err_acc u_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (launch),
    .valid     (pipe_valid),
    .err       (err),
`ifdef ABS_DIFF_FIRST_FAIL_EN
    .stim      (pipe_stim),
    .fail_vec  (fail_vec_o),
    .fail_seen (fail_seen_o),
`endif
    .finish    (state == DRAIN),
    .max_err   (max_err_o),
    .err_cnt   (err_cnt_o),
    .pass      (pass_o)
  );

  assign busy_o = (state == SWEEP) || (state == DRAIN);
  assign done_o = (state == DONE);

endmodule

// File: tb/tb_abs_diff_err_sweep.sv
// Self-checking bench for abs_diff_err_sweep.
// The bench plays the approximate circuit (loopback-exact, constant, or a
// random lookup table), computes the expected sweep results from plain
// arithmetic over all vectors, and queues them when a sweep is launched.
// A monitor pops and compares whenever done_o rises.
// Build with ABS_DIFF_FIRST_FAIL_EN to also check the first-fail capture.
module tb_abs_diff_err_sweep;

  localparam int IN_W  = 4;
  localparam int OUT_W = 3;
  localparam int ET    = 2;
  localparam int NVEC  = 1 << IN_W;
  localparam int HALF  = 1 << (IN_W / 2);
  localparam int LAT   = NVEC + 2;

  typedef struct {
    int max_err;
    int err_cnt;
    int pass;
    int fail_seen;
    int fail_vec;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start_i;
  logic [IN_W-1:0]  stim_o;
  logic [OUT_W-1:0] approx_i;
  logic             busy_o, done_o, pass_o;
  logic [OUT_W-1:0] max_err_o;
  logic [IN_W:0]    err_cnt_o;
`ifdef ABS_DIFF_FIRST_FAIL_EN
  logic [IN_W-1:0]  fail_vec_o;
  logic             fail_seen_o;
`endif

  int checks   = 0;
  int failures = 0;

  // Behaviour of the emulated approximate circuit.
  int               mode;       // 0 exact loopback, 1 constant, 2 random table
  logic [OUT_W-1:0] const_ap;
  logic [OUT_W-1:0] lut [NVEC];

  exp_t exp_q[$];
  exp_t got;
  logic done_prev = 1'b0;

  always #5 clk = ~clk;

  abs_diff_err_sweep dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .stim_o      (stim_o),
    .approx_i    (approx_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .pass_o      (pass_o),
    .max_err_o   (max_err_o),
`ifdef ABS_DIFF_FIRST_FAIL_EN
    .fail_vec_o  (fail_vec_o),
    .fail_seen_o (fail_seen_o),
`endif
    .err_cnt_o   (err_cnt_o)
  );

  function automatic int exact_of(input int v);
    int a, b;
    a = v % HALF;
    b = v / HALF;
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int approx_of(input int v);
    if (mode == 0) return exact_of(v);
    if (mode == 2) return int'(lut[v]);
    return int'(const_ap);
  endfunction

  assign approx_i = OUT_W'(approx_of(int'(stim_o)));

  // Reference: walk every vector in order with plain integer arithmetic.
  function automatic exp_t model_sweep();
    exp_t r;
    int   e, x, y;
    r = '{default: 0};
    for (int v = 0; v < NVEC; v++) begin
      x = exact_of(v);
      y = approx_of(v);
      e = (x > y) ? x - y : y - x;
      if (e > (1 << OUT_W) - 1) e = (1 << OUT_W) - 1;
      if (e > r.max_err) r.max_err = e;
      if (e != 0) r.err_cnt++;
      if (e > ET && r.fail_seen == 0) begin
        r.fail_seen = 1;
        r.fail_vec  = v;
      end
    end
    r.pass = (r.max_err <= ET) ? 1 : 0;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_mode(input int m, input int c);
    mode     = m;
    const_ap = OUT_W'(c);
    if (m == 2)
      for (int i = 0; i < NVEC; i++) lut[i] = OUT_W'($urandom_range(0, (1 << OUT_W) - 1));
  endtask

  // Monitor: every rising done_o must match the oldest outstanding sweep.
  always @(negedge clk) begin
    if (rst_n && done_o && !done_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        got = exp_q.pop_front();
        check("max_err", int'(max_err_o), got.max_err);
        check("err_cnt", int'(err_cnt_o), got.err_cnt);
        check("pass",    int'(pass_o),    got.pass);
`ifdef ABS_DIFF_FIRST_FAIL_EN
        check("fail_seen", int'(fail_seen_o), got.fail_seen);
        check("fail_vec",  int'(fail_vec_o),  got.fail_vec);
`endif
      end
    end
    done_prev = done_o;
  end

  // Called at posedge+1 with the DUT in IDLE or DONE. Optionally pulses
  // start_i twice mid-sweep, which must be ignored.
  task automatic run_sweep(input string tag, input int m, input int c, input bit glitch);
    int lat;
    set_mode(m, c);
    exp_q.push_back(model_sweep());
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = 1;
    check({tag, "_done_dropped"}, int'(done_o), 0);
    check({tag, "_busy"},         int'(busy_o), 1);
    check({tag, "_cnt_cleared"},  int'(err_cnt_o), 0);
    check({tag, "_stim0"},        int'(stim_o), 0);
    while (!done_o && lat < 3 * LAT) begin
      start_i = (glitch && (lat == 5 || lat == 10)) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start_i = 1'b0;
    check({tag, "_latency"}, done_o ? lat : -1, LAT);
    check({tag, "_stim_hold"}, int'(stim_o), NVEC - 1);
    check({tag, "_busy_low"},  int'(busy_o), 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start_i = 1'b0;
    set_mode(0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_stim",   int'(stim_o),    0);
    check("rst_busy",   int'(busy_o),    0);
    check("rst_done",   int'(done_o),    0);
    check("rst_pass",   int'(pass_o),    0);
    check("rst_max",    int'(max_err_o), 0);
    check("rst_cnt",    int'(err_cnt_o), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_done", int'(done_o), 0);

    run_sweep("loopback",  0, 0, 1'b0);
    run_sweep("const1",    1, 1, 1'b0);
    run_sweep("const0",    1, 0, 1'b0);
    run_sweep("glitch",    1, 1, 1'b1);

    // Reset in the middle of a sweep: nothing of it may survive.
    set_mode(1, 0);
    exp_q.push_back(model_sweep());
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_stim", int'(stim_o),    0);
    check("midrst_busy", int'(busy_o),    0);
    check("midrst_done", int'(done_o),    0);
    check("midrst_pass", int'(pass_o),    0);
    check("midrst_max",  int'(max_err_o), 0);
    check("midrst_cnt",  int'(err_cnt_o), 0);
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_sweep("post_rst", 0, 0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      run_sweep("rand_lut", 2, 0, 1'b0);
      run_sweep("rand_const", 1, int'($urandom_range(0, (1 << OUT_W) - 1)), 1'b0);
    end

    repeat (2) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
